// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stage-control vectors are packed as {pc, ifid_en, ifid_flush, idex, exmem, memwb}.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 3;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StDrain   = 2'd2,
    StHalted  = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
  } ctrl_t;

  // Everything advances normally.
  localparam ctrl_t CtrlRun    = 6'b110111;
  // Every stage holds.
  localparam ctrl_t CtrlFreeze = 6'b000000;
  // Front end holds, ID/EX takes a bubble, back end keeps draining.
  localparam ctrl_t CtrlStall  = 6'b000011;
  // Redirect: PC loads target, IF/ID loads a NOP, ID/EX takes a bubble.
  localparam ctrl_t CtrlFlush  = 6'b111011;
  // Halt seen in EX: PC holds, IF/ID loads a NOP, ID/EX takes a bubble.
  localparam ctrl_t CtrlHalt   = 6'b011011;
  // Only EX/MEM and MEM/WB continue while the back end retires.
  localparam ctrl_t CtrlDrain  = 6'b000011;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing and hazard controller for the 5-stage pipeline: stage enables,
// flushes and bubbles from load-use, branch/jump, memory waits and halt.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW      = pipeline_hazard_ctrl_pkg::REG_AW,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned DRAIN_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              ex_halt,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              memwb_en,
  output logic              halted,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned DrainW = $clog2(DRAIN_CYC + 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(MEM_TIMEOUT);
  localparam logic [DrainW-1:0] DrainMax = DrainW'(DRAIN_CYC);

  state_e            state_d, state_q;
  logic [WaitW-1:0]  wait_d, wait_q;
  logic [DrainW-1:0] drain_d, drain_q;
  logic              err_d, err_q;
  logic              halted_d, halted_q;
  ctrl_t             ctrl;
  logic              lu, mem_stall, redirect;
  logic              stall_inc, flush_inc;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  assign mem_stall = mem_req && !mem_ack;
  assign redirect  = ex_branch_taken || ex_jump;

  always_comb begin
    ctrl      = CtrlRun;
    state_d   = state_q;
    wait_d    = wait_q;
    drain_d   = drain_q;
    err_d     = err_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          ctrl    = CtrlFreeze;
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end else if (ex_halt) begin
          ctrl    = CtrlHalt;
          state_d = StDrain;
          drain_d = '0;
        end else if (redirect) begin
          ctrl      = CtrlFlush;
          flush_inc = 1'b1;
        end else if (lu) begin
          ctrl      = CtrlStall;
          stall_inc = 1'b1;
        end
      end
      StMemWait: begin
        // The ack cycle releases everything; hazards are picked up next cycle.
        if (mem_ack) begin
          ctrl    = CtrlRun;
          state_d = StRun;
          wait_d  = '0;
        end else begin
          ctrl   = CtrlFreeze;
          wait_d = wait_q + 1'b1;
          if (wait_d >= WaitMax) begin
            err_d   = 1'b1;
            state_d = StHalted;
          end
        end
      end
      StDrain: begin
        if (mem_stall) begin
          ctrl = CtrlFreeze;
        end else begin
          ctrl    = CtrlDrain;
          drain_d = drain_q + 1'b1;
          if (drain_d >= DrainMax) begin
            state_d = StHalted;
          end
        end
      end
      StHalted: begin
        ctrl = CtrlFreeze;
      end
      default: begin
        ctrl = CtrlFreeze;
      end
    endcase

    if (rst) begin
      ctrl      = CtrlRun;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end

    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      wait_q   <= '0;
      drain_q  <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      halted_q <= halted_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(stall_inc),
    .cnt(stall_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .clr(rst),
    .inc(flush_inc),
    .cnt(flush_cnt)
  );

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_en    = ctrl.idex_en;
  assign exmem_en   = ctrl.exmem_en;
  assign memwb_en   = ctrl.memwb_en;
  assign halted     = halted_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step queues its expected outputs
// when inputs are driven and checks them on the following falling edge.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [5:0]  ctl;
    logic        hlt;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  localparam logic [5:0] ALL1  = 6'b110111;
  localparam logic [5:0] ALL0  = 6'b000000;
  localparam logic [5:0] STALL = 6'b000011;
  localparam logic [5:0] FLUSH = 6'b111011;
  localparam logic [5:0] HALT  = 6'b011011;
  localparam logic [5:0] DRAIN = 6'b000011;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump, ex_halt;
  logic mem_req, mem_ack;
  logic pc_en, ifid_en, ifid_flush, idex_en, exmem_en, memwb_en, halted, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t sb_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .ex_halt(ex_halt),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .halted(halted), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic clear_in();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_jump = 0; ex_halt = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  // Inputs are already driven; queue expectation, check at negedge, advance one cycle.
  task automatic step(input string tag, input logic [5:0] ctl, input logic hlt,
                      input logic err, input bit s_inc, input bit f_inc);
    exp_t e, obs;
    sb_q.push_back('{ctl: ctl, hlt: hlt, err: err, sc: exp_stall, fc: exp_flush});
    @(negedge clk);
    e   = sb_q.pop_front();
    obs = '{ctl: {pc_en, ifid_en, ifid_flush, idex_en, exmem_en, memwb_en},
            hlt: halted, err: mem_err, sc: stall_cnt, fc: flush_cnt};
    n_chk++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: ctl/hlt/err/stall/flush observed %b/%b/%b/%h/%h required %b/%b/%b/%h/%h",
             tag, obs.ctl, obs.hlt, obs.err, obs.sc, obs.fc,
             e.ctl, e.hlt, e.err, e.sc, e.fc);
    end
    if (s_inc && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    if (f_inc && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic hlt, input logic err);
    rst = 1;
    step("reset", ALL1, hlt, err, 0, 0);
    exp_stall = '0;
    exp_flush = '0;
    rst = 0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    @(posedge clk);
    #1;
    step("reset_hold", ALL1, 0, 0, 0, 0);
    rst = 0;
    step("idle", ALL1, 0, 0, 0, 0);

    // Load-use through rs, then bubble clears the load.
    ex_mem_read = 1; ex_rt = 3; id_rs = 3; id_uses_rs = 1;
    step("lu_rs", STALL, 0, 0, 1, 0);
    ex_mem_read = 0;
    step("lu_release", ALL1, 0, 0, 0, 0);
    ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    step("lu_r0", ALL1, 0, 0, 0, 0);
    ex_rt = 5; id_rt = 5; id_uses_rt = 1; id_uses_rs = 0; id_rs = 2;
    step("lu_rt", STALL, 0, 0, 1, 0);
    id_uses_rt = 0;
    step("lu_rt_unused", ALL1, 0, 0, 0, 0);

    // Branch wins over a concurrent load-use; jump alone also flushes.
    id_uses_rt = 1; ex_branch_taken = 1;
    step("branch_lu", FLUSH, 0, 0, 0, 1);
    clear_in(); ex_jump = 1;
    step("jump", FLUSH, 0, 0, 0, 1);
    clear_in();
    step("post_flush", ALL1, 0, 0, 0, 0);

    // Memory wait acked on the fifth cycle; hazards ignored on the ack cycle.
    mem_req = 1;
    for (int i = 0; i < 5; i++) step("mem_wait", ALL0, 0, 0, 0, 0);
    mem_ack = 1; ex_branch_taken = 1;
    step("mem_ack", ALL1, 0, 0, 0, 0);
    clear_in();
    step("mem_back_run", ALL1, 0, 0, 0, 0);

    // Timeout: 64 waiting cycles then error and halt.
    mem_req = 1;
    for (int i = 0; i < 64; i++) step("mem_timeout_wait", ALL0, 0, 0, 0, 0);
    step("mem_timeout_halt", ALL0, 1, 1, 0, 0);
    clear_in();
    do_reset(1, 1);
    step("post_reset", ALL1, 0, 0, 0, 0);

    // Halt drain, then halted ignores a branch.
    ex_halt = 1;
    step("halt", HALT, 0, 0, 0, 0);
    ex_halt = 0;
    step("drain0", DRAIN, 0, 0, 0, 0);
    step("drain1", DRAIN, 0, 0, 0, 0);
    step("halted", ALL0, 1, 0, 0, 0);
    ex_branch_taken = 1;
    step("halted_branch", ALL0, 1, 0, 0, 0);
    clear_in();
    step("halted_hold", ALL0, 1, 0, 0, 0);
    do_reset(1, 0);

    // Memory stall during drain freezes and pauses the drain timer.
    ex_halt = 1;
    step("halt2", HALT, 0, 0, 0, 0);
    ex_halt = 0; mem_req = 1;
    for (int i = 0; i < 3; i++) step("drain_mem_freeze", ALL0, 0, 0, 0, 0);
    mem_req = 0;
    step("drain_resume0", DRAIN, 0, 0, 0, 0);
    step("drain_resume1", DRAIN, 0, 0, 0, 0);
    step("halted2", ALL0, 1, 0, 0, 0);
    do_reset(1, 0);

    // Reset in the middle of a memory wait returns to RUN.
    mem_req = 1;
    step("mw_a", ALL0, 0, 0, 0, 0);
    step("mw_b", ALL0, 0, 0, 0, 0);
    do_reset(0, 0);
    mem_req = 0;
    step("mw_reset_run", ALL1, 0, 0, 0, 0);

    // Saturation: more than 65535 load-use cycles must stop at all-ones.
    ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_uses_rs = 1;
    for (int i = 0; i < 65537; i++) step("lu_sat", STALL, 0, 0, 1, 0);
    clear_in();
    step("sat_final", ALL1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
